// File: rtl/proc_mc_if.sv
// Program-load, run/status and debug-read bundle for the proc_mc core.
interface proc_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_wdata;
    logic              run;
    logic              busy;
    logic              halted;
    logic              err;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic [2:0]        flags;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output prog_we, prog_addr, prog_wdata, run, dbg_sel,
        input  busy, halted, err, pc, instr, flags, dbg_data
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, run, dbg_sel,
        output busy, halted, err, pc, instr, flags, dbg_data
    );
endinterface

// File: rtl/proc_mc.sv
// proc_mc: multicycle Processor-Z core (program RAM, register file, ALU, sequencer).
// Define PROC_MC_JUMP_EN to add the jmp/je/jne group on icode 0x7.
module proc_mc #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int NREG   = 8
) (
    input  logic     clock,
    input  logic     reset_n,
    proc_mc_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED} state_t;
    typedef logic [NREG-1:0][DATA_W-1:0] regs_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [2:0]        flags_q, flags_d, fl_new_q, fl_new_d;
    logic              err_q, err_d, busy_q, busy_d, halted_q, halted_d;
    regs_t             regs_q, regs_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic              wr_en_q, wr_en_d, fl_wr_q, fl_wr_d;
    logic [3:0]        wr_idx_q, wr_idx_d;
`ifdef PROC_MC_JUMP_EN
    logic              jmp_q, jmp_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
`endif

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] ram_rdata_q;
    logic        prog_wr;

    logic [3:0]        icode, ifun, ra, rb;
    logic              ra_ok, rb_ok, ex_illegal, ex_halt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_of;

    function automatic logic [DATA_W-1:0] rd_reg(input regs_t r, input logic [3:0] idx);
        rd_reg = '0;
        for (int i = 0; i < NREG; i++)
            if (idx == 4'(i)) rd_reg = r[i];
    endfunction

    assign icode = instr_q[31:28];
    assign ifun  = instr_q[27:24];
    assign ra    = instr_q[23:20];
    assign rb    = instr_q[19:16];
    assign ra_ok = int'(ra) < NREG;
    assign rb_ok = int'(rb) < NREG;

    // Loading is only allowed while the sequencer is parked.
    assign prog_wr = bus.prog_we && (state_q == S_IDLE || state_q == S_HALTED);

    always_ff @(posedge clock) begin
        if (prog_wr) mem[bus.prog_addr] <= bus.prog_wdata;
        if (state_q == S_FETCH) ram_rdata_q <= mem[pc_q];
    end

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (ifun[1:0])
            2'd0: begin
                alu_res = opa_q + opb_q;
                alu_of  = (opa_q[DATA_W-1] == opb_q[DATA_W-1]) && (alu_res[DATA_W-1] != opa_q[DATA_W-1]);
            end
            2'd1: begin
                alu_res = opa_q - opb_q;
                alu_of  = (opa_q[DATA_W-1] != opb_q[DATA_W-1]) && (alu_res[DATA_W-1] != opa_q[DATA_W-1]);
            end
            2'd2:    alu_res = opa_q & opb_q;
            default: alu_res = opa_q ^ opb_q;
        endcase
    end

    always_comb begin
        ex_illegal = 1'b1;
        ex_halt    = 1'b0;
        unique case (icode)
            4'h0: ex_illegal = (ifun != 4'h0);
            4'h1: ex_illegal = (ifun != 4'h0) || !rb_ok;
            4'h2: ex_illegal = (ifun > 4'h3) || !ra_ok || !rb_ok;
            4'h3: begin
                ex_halt    = (ifun == 4'h0);
                ex_illegal = !ex_halt;
            end
`ifdef PROC_MC_JUMP_EN
            4'h7: ex_illegal = (ifun > 4'h2);
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        flags_d  = flags_q;
        err_d    = err_q;
        regs_d   = regs_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        wr_en_d  = wr_en_q;
        wr_idx_d = wr_idx_q;
        fl_wr_d  = fl_wr_q;
        fl_new_d = fl_new_q;
`ifdef PROC_MC_JUMP_EN
        jmp_d    = jmp_q;
        tgt_d    = tgt_q;
`endif
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                instr_d = ram_rdata_q;
                opa_d   = rd_reg(regs_q, ram_rdata_q[23:20]);
                opb_d   = rd_reg(regs_q, ram_rdata_q[19:16]);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wr_en_d  = 1'b0;
                fl_wr_d  = 1'b0;
                wr_idx_d = (icode == 4'h1) ? rb : ra;
                res_d    = (icode == 4'h1) ? DATA_W'(instr_q[15:0]) : alu_res;
                fl_new_d = {alu_res == '0, alu_res[DATA_W-1], alu_of};
`ifdef PROC_MC_JUMP_EN
                jmp_d    = (icode == 4'h7) && ((ifun == 4'h0) ||
                           (ifun == 4'h1 && flags_q[2]) || (ifun == 4'h2 && !flags_q[2]));
                tgt_d    = instr_q[ADDR_W-1:0];
`endif
                // Halt and illegal words park with pc still on the offending address.
                if (ex_illegal || ex_halt) begin
                    state_d = S_HALTED;
                    err_d   = ex_illegal;
                end else begin
                    state_d = S_WB;
                    wr_en_d = (icode == 4'h1) || (icode == 4'h2);
                    fl_wr_d = (icode == 4'h2);
                end
            end
            S_WB: begin
                for (int i = 0; i < NREG; i++)
                    if (wr_en_q && wr_idx_q == 4'(i)) regs_d[i] = res_q;
                if (fl_wr_q) flags_d = fl_new_q;
                pc_d = pc_q + ADDR_W'(1);
`ifdef PROC_MC_JUMP_EN
                if (jmp_q) pc_d = tgt_q;
`endif
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = state_d inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            regs_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            fl_wr_q  <= 1'b0;
            fl_new_q <= '0;
`ifdef PROC_MC_JUMP_EN
            jmp_q    <= 1'b0;
            tgt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            regs_q   <= regs_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            fl_wr_q  <= fl_wr_d;
            fl_new_q <= fl_new_d;
`ifdef PROC_MC_JUMP_EN
            jmp_q    <= jmp_d;
            tgt_q    <= tgt_d;
`endif
        end
    end

    always_comb begin
        bus.dbg_data = '0;
        for (int i = 0; i < NREG; i++)
            if (bus.dbg_sel == 4'(i)) bus.dbg_data = regs_q[i];
    end

    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;
    assign bus.err    = err_q;
    assign bus.pc     = pc_q;
    assign bus.instr  = instr_q;
    assign bus.flags  = flags_q;
endmodule

// File: tb/tb_proc_mc.sv
// Scoreboard bench for proc_mc: an ISA-level interpreter predicts each run's final state.
module tb_proc_mc;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int NR = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    proc_mc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    proc_mc #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic        err;
        int          pc;
        int          cycles;
        logic [2:0]  flags;
        logic [31:0] instr;
        int          regs[NR];
    } exp_t;

    exp_t        q[$];
    logic [31:0] tb_mem[512];
    int          m_reg[NR];
    logic [2:0]  m_flags;
    int          checks = 0, failures = 0;
    int          cyc = 0, run_cyc = 0, done_cnt = 0, pushed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = 0;
        m_flags = 3'b000;
    endtask

    // Instruction-by-instruction interpreter; cost is 4 cycles per retired instruction + 3 to park.
    task automatic model_run(output exp_t e);
        int pc = 0, n = 0, nxt;
        bit done = 0;
        logic [31:0] w;
        int ic, fn, ra, rb, vc, a, b, r, sa, sb, s;
        e.err = 1'b0;
        while (!done && n < 4000) begin
            w  = tb_mem[pc];
            ic = int'(w[31:28]);
            fn = int'(w[27:24]);
            ra = int'(w[23:20]);
            rb = int'(w[19:16]);
            vc = int'(w[15:0]);
            nxt = (pc + 1) % 512;
            if (ic == 0 && fn == 0) begin
            end else if (ic == 1 && fn == 0 && rb < NR) begin
                m_reg[rb] = vc;
            end else if (ic == 2 && fn < 4 && ra < NR && rb < NR) begin
                a  = m_reg[ra];
                b  = m_reg[rb];
                sa = (a >= 32768) ? a - 65536 : a;
                sb = (b >= 32768) ? b - 65536 : b;
                case (fn)
                    0:       s = sa + sb;
                    1:       s = sa - sb;
                    2:       s = a & b;
                    default: s = a ^ b;
                endcase
                r = s & 32'hFFFF;
                m_flags = {r == 0, r >= 32768, (fn < 2) && (s > 32767 || s < -32768)};
                m_reg[ra] = r;
            end else if (ic == 3 && fn == 0) begin
                done = 1;
`ifdef PROC_MC_JUMP_EN
            end else if (ic == 7 && fn < 3) begin
                if (fn == 0 || (fn == 1 && m_flags[2]) || (fn == 2 && !m_flags[2])) nxt = vc % 512;
`endif
            end else begin
                e.err = 1'b1;
                done  = 1;
            end
            if (!done) begin
                n++;
                pc = nxt;
            end
        end
        e.pc     = pc;
        e.cycles = 4 * n + 3;
        e.flags  = m_flags;
        e.instr  = tb_mem[pc];
        foreach (e.regs[i]) e.regs[i] = m_reg[i];
    endtask

    task automatic load(input int a, input logic [31:0] w);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = AW'(a);
        bus.prog_wdata = w;
        tb_mem[a]      = w;
        @(negedge clock);
        bus.prog_we = 1'b0;
    endtask

    task automatic start_run(input bit push, input bit wr, input logic [31:0] w0);
        exp_t e;
        bus.run = 1'b1;
        if (wr) begin
            bus.prog_we    = 1'b1;
            bus.prog_addr  = '0;
            bus.prog_wdata = w0;
            tb_mem[0]      = w0;
        end
        if (push) begin
            model_run(e);
            q.push_back(e);
            pushed++;
        end
        @(negedge clock);
        bus.run     = 1'b0;
        bus.prog_we = 1'b0;
        run_cyc     = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt < pushed && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (done_cnt < pushed) begin
            failures++;
            $display("FAIL timeout: got done=%0d expected %0d", done_cnt, pushed);
            q.delete();
            done_cnt = pushed;
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        int k = $urandom_range(0, 99);
        if (k < 40) return {8'h10, 4'hF, 4'($urandom_range(0, NR - 1)), 16'($urandom)};
        if (k < 92) return {4'h2, 4'($urandom_range(0, 3)), 4'($urandom_range(0, NR - 1)),
                            4'($urandom_range(0, NR - 1)), 16'($urandom)};
        return {8'h00, 24'($urandom)};
    endfunction

    // Monitor: on each rising halted, pop the prediction and compare status plus every debug slot.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        bus.dbg_sel = 4'd0;
        forever begin
            @(negedge clock);
            if (bus.halted && !prev) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_halt: got halted=1 expected no halt");
                end else begin
                    e = q.pop_front();
                    chk("err", bus.err, e.err);
                    chk("pc", bus.pc, e.pc);
                    chk("flags", bus.flags, e.flags);
                    chk("instr", bus.instr, e.instr);
                    chk("cycles", cyc - run_cyc, e.cycles);
                    for (int i = 0; i < 16; i++) begin
                        bus.dbg_sel = 4'(i);
                        #1;
                        chk($sformatf("reg%0d", i), bus.dbg_data, (i < NR) ? e.regs[i] : 0);
                    end
                    bus.dbg_sel = 4'd0;
                end
                done_cnt++;
            end
            prev = bus.halted;
        end
    end

    logic [31:0] ill[7];

    initial begin
        int n;
        ill = '{32'h50000000, 32'h28000000, 32'h10F80000, 32'h20800000,
                32'h20080000, 32'h01000000, 32'h31000000};
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.run        = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_flags", bus.flags, 0);
        chk("rst_dbg", bus.dbg_data, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // irmov r0..r7 then halt; a write attempted while busy must not land.
        for (int i = 0; i < 8; i++) load(i, 32'h10F00080 + (i << 16) + i);
        load(8, 32'h30000000);
        start_run(1, 0, 0);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 9'd8;
        bus.prog_wdata = 32'h50000000;
        repeat (2) @(negedge clock);
        bus.prog_we = 1'b0;
        wait_done();

        // sub to zero
        load(0, 32'h10F00005); load(1, 32'h10F10005); load(2, 32'h21010000); load(3, 32'h30000000);
        start_run(1, 0, 0);
        wait_done();

        // signed overflow on add
        load(0, 32'h10F07FFF); load(1, 32'h20000000); load(2, 32'h30000000);
        start_run(1, 0, 0);
        wait_done();

        // illegal opcode at address 0
        load(0, 32'h50000000);
        start_run(1, 0, 0);
        wait_done();

        // jne count-down loop (illegal when jumps are not built in)
        load(0, 32'h10F00003); load(1, 32'h10F10001); load(2, 32'h21010000);
        load(3, 32'h72000002); load(4, 32'h30000000);
        start_run(1, 0, 0);
        wait_done();

        // write to address 0 in the same cycle as run
        load(0, 32'h10F30042); load(1, 32'h30000000);
        start_run(1, 1, 32'h30000000);
        wait_done();

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(2, 10);
            for (int k = 0; k < n; k++) load(k, rnd_instr());
            load(n, ($urandom_range(0, 3) == 0) ? ill[$urandom_range(0, 6)] : 32'h30000000);
            start_run(1, 0, 0);
            wait_done();
        end

        // reset during EXEC of an add: the pending write is lost
        load(0, 32'h10F10001); load(1, 32'h10F20002); load(2, 32'h20120000); load(3, 32'h30000000);
        start_run(0, 0, 0);
        repeat (10) @(negedge clock);
        chk("exec_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_halted", bus.halted, 1'b0);
        chk("mid_err", bus.err, 1'b0);
        chk("mid_pc", bus.pc, 0);
        chk("mid_instr", bus.instr, 0);
        chk("mid_flags", bus.flags, 0);
        chk("mid_dbg", bus.dbg_data, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        load(0, 32'h30000000);
        start_run(1, 0, 0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
